// File: rtl/pll_div_gen.sv
// Multi-channel programmable clock divider with emulated PLL lock interval.
// Each channel produces a registered 50% square wave and a tick on every toggle.
module pll_div_gen #(
   parameter int CHANNELS    = 2,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 1,
   parameter int LOCK_CYCLES = 16,
   parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                ck,
   input  logic                rst_n,
   input  logic                bypass,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_chan,
   input  logic [DIV_W-1:0]    wr_div,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic                lock
);

   localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);

   typedef enum logic {
      LOCKING,
      LOCKED
   } lock_state_t;

   lock_state_t       state_q, state_d;
   logic [LCNT_W-1:0] lcnt_q, lcnt_d;

   logic [DIV_W-1:0]  div    [CHANNELS];
   logic [DIV_W-1:0]  cnt    [CHANNELS];
   logic [DIV_W-1:0]  effdiv [CHANNELS];
   logic [CHANNELS-1:0] active;
   logic [CHANNELS-1:0] term;
   logic              wr_hit;

   // Out-of-range channel writes are dropped entirely, including the relock.
   assign wr_hit = wr_en && (int'(wr_chan) < CHANNELS);
   assign lock   = (state_q == LOCKED);

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      lcnt_d  = lcnt_q;
      case (state_q)
         LOCKING: begin
            lcnt_d = lcnt_q + 1'b1;
            if (lcnt_q == LCNT_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
         end
         default: ;
      endcase
      if (wr_hit) begin
         state_d = LOCKING;
         lcnt_d  = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge ck) begin
      if (!rst_n) begin
         state_q <= LOCKING;
         lcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         lcnt_q  <= lcnt_d;
      end
   end

   // Terminal uses >= so a smaller divisor after a bypass change cannot overrun the count.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         effdiv[i] = bypass ? DIV_W'(1) : div[i];
         active[i] = (lock || bypass) && (effdiv[i] != '0);
         term[i]   = (cnt[i] >= effdiv[i] - 1'b1);
      end
   end

   // NOTE: the divisor array is a small register file and is reset explicitly, unlike a RAM.
   always_ff @(posedge ck) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            div[i] <= DIV_W'(DEFAULT_DIV);
            cnt[i] <= '0;
         end
         clk_out <= '0;
         tick    <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_hit && (int'(wr_chan) == i)) div[i] <= wr_div;
            if (wr_hit || !active[i]) begin
               cnt[i]     <= '0;
               tick[i]    <= 1'b0;
               clk_out[i] <= 1'b0;
            end else if (term[i]) begin
               cnt[i]     <= '0;
               tick[i]    <= 1'b1;
               clk_out[i] <= ~clk_out[i];
            end else begin
               cnt[i]     <= cnt[i] + 1'b1;
               tick[i]    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pll_div_gen.sv
// Self-checking bench for pll_div_gen: directed scenarios then randomized traffic
// compared every cycle against an edge-counting reference model.
module tb_pll_div_gen;

   localparam int CH  = 3;
   localparam int DW  = 8;
   localparam int DEF = 1;
   localparam int LC  = 16;
   localparam int CW  = 2;

   logic          ck = 1'b0;
   logic          rst_n, bypass, wr_en;
   logic [CW-1:0] wr_chan;
   logic [DW-1:0] wr_div;
   logic [CH-1:0] clk_out, tick;
   logic          lock;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // reference model state
   int m_div  [CH];
   int m_el   [CH];
   bit m_clk  [CH];
   bit m_tick [CH];
   int m_edges;
   bit m_lock;

   pll_div_gen #(
      .CHANNELS(CH), .DIV_W(DW), .DEFAULT_DIV(DEF), .LOCK_CYCLES(LC)
   ) dut (
      .ck(ck), .rst_n(rst_n), .bypass(bypass), .wr_en(wr_en),
      .wr_chan(wr_chan), .wr_div(wr_div),
      .clk_out(clk_out), .tick(tick), .lock(lock)
   );

   always #5 ck = ~ck;

   task automatic check(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   // Model: a channel ticks once it has seen effdiv active edges since its last tick;
   // lock is simply "at least LC edges since the last reset or accepted write".
   task automatic model_edge();
      bit hit;
      bit was_locked;
      int eff;
      hit        = wr_en && (int'(wr_chan) < CH);
      was_locked = m_lock;
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) begin
            m_div[c] = DEF; m_el[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
         end
         m_edges = 0;
         m_lock  = 0;
         return;
      end
      for (int c = 0; c < CH; c++) begin
         eff = bypass ? 1 : m_div[c];
         if (hit || !(was_locked || bypass) || eff == 0) begin
            m_el[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
         end else begin
            m_el[c]++;
            if (m_el[c] >= eff) begin
               m_tick[c] = 1; m_clk[c] = !m_clk[c]; m_el[c] = 0;
            end else begin
               m_tick[c] = 0;
            end
         end
      end
      if (hit) begin
         m_div[int'(wr_chan)] = int'(wr_div);
         m_edges = 0;
         m_lock  = 0;
      end else if (m_edges < LC) begin
         m_edges++;
         m_lock = (m_edges >= LC);
      end
   endtask

   task automatic compare();
      for (int c = 0; c < CH; c++) begin
         check($sformatf("clk_out[%0d]", c), int'(clk_out[c]), int'(m_clk[c]));
         check($sformatf("tick[%0d]", c), int'(tick[c]), int'(m_tick[c]));
      end
      check("lock", int'(lock), int'(m_lock));
   endtask

   task automatic step();
      @(posedge ck);
      model_edge();
      @(negedge ck);
      compare();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic write(input int chan, input int d);
      wr_en = 1'b1; wr_chan = CW'(chan); wr_div = DW'(d);
      step();
      wr_en = 1'b0;
   endtask

   // Cycles between two consecutive ticks of a channel; -1 if a bound expires.
   task automatic tick_gap(input int c, output int gap);
      int n;
      gap = -1;
      n = 0;
      while (!tick[c] && n < 60) begin step(); n++; end
      if (!tick[c]) return;
      n = 0;
      do begin step(); n++; end while (!tick[c] && n < 60);
      if (tick[c]) gap = n;
   endtask

   initial begin
      int n, gap;
      bit saved_lock;
      rst_n = 1'b0; bypass = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_div = '0;
      m_edges = 0; m_lock = 0;
      for (int c = 0; c < CH; c++) begin
         m_div[c] = DEF; m_el[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end
      @(negedge ck);
      run(2);
      check("reset_lock", int'(lock), 0);
      check("reset_clk_out", int'(clk_out), 0);

      // lock latency after reset release
      rst_n = 1'b1;
      n = 0;
      do begin step(); n++; end while (!lock && n < 40);
      check("lock_latency", n, LC);
      run(4);
      check("div1_tick0", int'(tick[0]), 1);

      // divide-by-3 on channel 1
      write(1, 3);
      check("lock_drop", int'(lock), 0);
      run(LC + 4);
      tick_gap(1, gap);
      check("div3_gap", gap, 3);

      // channel 0 disabled
      write(0, 0);
      run(LC + 10);
      check("div0_clk_out", int'(clk_out[0]), 0);
      check("div0_tick", int'(tick[0]), 0);

      // bypass while relocking with divisor 5, then return to divide-by-5
      write(0, 5);
      bypass = 1'b1;
      run(3);
      check("bypass_tick0", int'(tick[0]), 1);
      bypass = 1'b0;
      run(LC);
      tick_gap(0, gap);
      check("div5_gap", gap, 5);

      // out-of-range channel write is ignored
      saved_lock = lock;
      write(CH, 2);
      check("oob_lock", int'(lock), int'(saved_lock));
      run(12);

      // reset mid-count wins over a simultaneous write
      rst_n = 1'b0; wr_en = 1'b1; wr_chan = 2'd1; wr_div = 8'd7;
      step();
      check("rst_outputs", int'({clk_out, tick, lock}), 0);
      rst_n = 1'b1; wr_en = 1'b0;
      run(LC + 6);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst_n   = ($urandom_range(0, 199) != 0);
         wr_en   = ($urandom_range(0, 29) == 0);
         wr_chan = CW'($urandom_range(0, 3));
         wr_div  = DW'($urandom_range(0, 6));
         if ($urandom_range(0, 49) == 0) bypass = ~bypass;
         step();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
